// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one byte-addressed data memory between an instruction-fetch port (read-only)
//   and a load/store port (read/write). One transaction at a time runs through
//   IDLE -> ISSUE -> WAIT -> RESP. Round-robin on ties: the port not granted last wins.
//   A WAIT that sees no matching done for TIMEOUT_CYCLES cycles ends with an error response.
//
//   Optional feature: define MEM_ALIGN_CHECK_EN to reject non-word-aligned addresses
//   straight from IDLE with err=1 and no memory access.
//
// Ports
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   if_req/if_addr               fetch request and byte address (held until if_ack)
//   if_ack/if_rdata/if_err       one-cycle fetch completion with data and error
//   d_req/d_we/d_addr/d_wdata    load/store request, direction, address, store data
//   d_ack/d_rdata/d_err          one-cycle load/store completion (rdata 0 for stores)
//   mem_read/mem_write           one-cycle memory strobes
//   mem_read_addr/mem_write_addr memory addresses (valid with the strobe)
//   mem_wr_data                  memory write data
//   mem_rd_data/mem_rd_done      read data and registered read done
//   mem_wr_done                  registered write done
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_done,
  input  logic                  mem_wr_done
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  // Port encoding: 0 = fetch, 1 = load/store.
  localparam logic PortD = 1'b1;

  state_e                state_q, state_d;
  logic                  port_q, port_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  last_q, last_d;

  logic                  grant;
  logic [ADDR_WIDTH-1:0] sel_addr;

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    // Tie goes to the port that was not granted last; a lone request simply wins.
    grant    = (if_req && d_req) ? ~last_q : d_req;
    sel_addr = grant ? d_addr : if_addr;

    unique case (state_q)
      StIdle: begin
        if (if_req || d_req) begin
          port_d  = grant;
          we_d    = grant & d_we;
          addr_d  = sel_addr;
          wdata_d = grant ? d_wdata : '0;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = StIssue;
`ifdef MEM_ALIGN_CHECK_EN
          if (sel_addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = StResp;
          end
`endif
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // Only the done that matches the latched op counts.
        if (we_q ? mem_wr_done : mem_rd_done) begin
          rdata_d = we_q ? '0 : mem_rd_data;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        last_d  = port_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    if_ack         = 1'b0;
    if_rdata       = '0;
    if_err         = 1'b0;
    d_ack          = 1'b0;
    d_rdata        = '0;
    d_err          = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_read_addr  = '0;
    mem_write_addr = '0;
    mem_wr_data    = '0;
    if (state_q == StIssue) begin
      mem_read       = ~we_q;
      mem_write      = we_q;
      mem_read_addr  = addr_q;
      mem_write_addr = addr_q;
      mem_wr_data    = wdata_q;
    end
    if (state_q == StResp) begin
      if (port_q == PortD) begin
        d_ack   = 1'b1;
        d_rdata = rdata_q;
        d_err   = err_q;
      end else begin
        if_ack   = 1'b1;
        if_rdata = rdata_q;
        if_err   = err_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= PortD;  // so fetch wins the first tie
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed transactions against a word memory model
// with registered done signals. Define MEM_ALIGN_CHECK_EN to match the DUT build.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_ack, if_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_ack, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_read_addr, mem_write_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;
  logic          mem_rd_done = 1'b0;
  logic          mem_wr_done = 1'b0;

  logic          suppress_rd;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;
  logic [DW-1:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  int            r_lat, r_nrd, r_nwr, r_strobe_at;
  logic [DW-1:0] r_rdata, r_swdata;
  logic          r_err;
  logic [AW-1:0] r_saddr;
  bit            r_other, r_acked;
  bit            seen_ack;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_ack        (if_ack),
    .if_rdata      (if_rdata),
    .if_err        (if_err),
    .d_req         (d_req),
    .d_we          (d_we),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_ack         (d_ack),
    .d_rdata       (d_rdata),
    .d_err         (d_err),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_read_addr (mem_read_addr),
    .mem_write_addr(mem_write_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_rd_data   (mem_rd_data),
    .mem_rd_done   (mem_rd_done),
    .mem_wr_done   (mem_wr_done)
  );

  // Word memory; done flags are registered one cycle after the strobe.
  always @(posedge clk) begin
    mem_rd_done <= 1'b0;
    mem_wr_done <= 1'b0;
    if (bd_we) mem[bd_addr[AW-1:2]] <= bd_data;
    if (mem_read) begin
      mem_rd_data <= mem[mem_read_addr[AW-1:2]];
      mem_rd_done <= ~suppress_rd;
    end
    if (mem_write) begin
      mem[mem_write_addr[AW-1:2]] <= mem_wr_data;
      mem_wr_done <= 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = v;
    tick();
    bd_we   = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ctl"}, {if_ack, if_err, d_ack, d_err, mem_read, mem_write,
                             mem_read_addr, mem_write_addr}, '0);
    check_eq({tag, "_data"}, if_rdata | d_rdata | mem_wr_data, '0);
  endtask

  // Starts a request in an IDLE cycle, waits (bounded) for its ack, records strobes seen,
  // then drops the request and steps one more cycle back to IDLE.
  task automatic run_req(input string tag, input bit is_d, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
    r_lat = 0; r_nrd = 0; r_nwr = 0; r_strobe_at = 0; r_saddr = '0; r_swdata = '0;
    r_other = 0; r_acked = 0; r_rdata = '0; r_err = 1'b0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    for (int i = 1; i <= 40 && !r_acked; i++) begin
      tick();
      if ((mem_read || mem_write) && r_strobe_at == 0) begin
        r_strobe_at = i;
        r_saddr     = mem_read ? mem_read_addr : mem_write_addr;
        r_swdata    = mem_wr_data;
      end
      if (mem_read) r_nrd++;
      if (mem_write) r_nwr++;
      if (is_d ? if_ack : d_ack) r_other = 1;
      if (is_d ? d_ack : if_ack) begin
        r_acked = 1;
        r_lat   = i;
        r_rdata = is_d ? d_rdata : if_rdata;
        r_err   = is_d ? d_err : if_err;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    check_eq({tag, "_acked"}, 64'(r_acked), 1);
    check_eq({tag, "_other_ack"}, 64'(r_other), 0);
    tick();
    check_eq({tag, "_ack_pulse"}, {if_ack, d_ack}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; suppress_rd = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    tick();
    tick();
    check_idle_outputs("reset");
    rst = 1'b0;

    // 1: fetch from a preloaded word
    preload(10'h010, 32'hDEADBEEF);
    run_req("t1", 1'b0, 1'b0, 10'h010, '0);
    check_eq("t1_lat", r_lat, 3);
    check_eq("t1_nrd", r_nrd, 1);
    check_eq("t1_nwr", r_nwr, 0);
    check_eq("t1_strobe_at", r_strobe_at, 1);
    check_eq("t1_addr", r_saddr, 10'h010);
    check_eq("t1_rdata", r_rdata, 32'hDEADBEEF);
    check_eq("t1_err", r_err, 0);

    // 2: store then fetch back
    run_req("t2st", 1'b1, 1'b1, 10'h020, 32'h12345678);
    check_eq("t2st_lat", r_lat, 3);
    check_eq("t2st_nwr", r_nwr, 1);
    check_eq("t2st_addr", r_saddr, 10'h020);
    check_eq("t2st_wdata", r_swdata, 32'h12345678);
    check_eq("t2st_rdata", r_rdata, 0);
    check_eq("t2st_err", r_err, 0);
    run_req("t2ld", 1'b0, 1'b0, 10'h020, '0);
    check_eq("t2ld_rdata", r_rdata, 32'h12345678);
    check_eq("t2ld_err", r_err, 0);

    // 3: both ports held high after reset -> IF, D, IF, D every 4 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 10'h010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_eq($sformatf("t3_if_ack_c%0d", k), if_ack, (k == 3 || k == 11));
      check_eq($sformatf("t3_d_ack_c%0d", k), d_ack, (k == 7 || k == 15));
      if (k == 3) check_eq("t3_if_rdata", if_rdata, 32'hDEADBEEF);
      if (k == 7) check_eq("t3_d_rdata", d_rdata, 32'h12345678);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();

    // 4: read done suppressed -> timeout error, then normal completion
    suppress_rd = 1'b1;
    run_req("t4", 1'b1, 1'b0, 10'h030, '0);
    check_eq("t4_lat", r_lat, 2 + TO);
    check_eq("t4_err", r_err, 1);
    check_eq("t4_rdata", r_rdata, 0);
    check_eq("t4_nrd", r_nrd, 1);
    suppress_rd = 1'b0;
    preload(10'h030, 32'hCAFEF00D);
    run_req("t4b", 1'b1, 1'b0, 10'h030, '0);
    check_eq("t4b_lat", r_lat, 3);
    check_eq("t4b_err", r_err, 0);
    check_eq("t4b_rdata", r_rdata, 32'hCAFEF00D);

    // 5: reset while in WAIT drops the transaction
    if_req = 1'b1; if_addr = 10'h010;
    tick();
    check_eq("t5_issue_rd", mem_read, 1);
    tick();
    rst = 1'b1;
    if_req = 1'b0;
    tick();
    check_idle_outputs("t5_rst");
    rst = 1'b0;
    seen_ack = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (if_ack || d_ack) seen_ack = 1;
    end
    check_eq("t5_no_ack", 64'(seen_ack), 0);
    run_req("t5", 1'b0, 1'b0, 10'h010, '0);
    check_eq("t5_lat", r_lat, 3);
    check_eq("t5_rdata", r_rdata, 32'hDEADBEEF);

    // 6: unaligned store
    run_req("t6", 1'b1, 1'b1, 10'h021, 32'hA5A5A5A5);
`ifdef MEM_ALIGN_CHECK_EN
    check_eq("t6_lat", r_lat, 1);
    check_eq("t6_err", r_err, 1);
    check_eq("t6_rdata", r_rdata, 0);
    check_eq("t6_nwr", r_nwr, 0);
    run_req("t6ld", 1'b0, 1'b0, 10'h020, '0);
    check_eq("t6ld_rdata", r_rdata, 32'h12345678);
`else
    check_eq("t6_lat", r_lat, 3);
    check_eq("t6_err", r_err, 0);
    check_eq("t6_nwr", r_nwr, 1);
    check_eq("t6_addr", r_saddr, 10'h021);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
